// File: rtl/jesd204_tx_lane_64b.sv
// rtl/jesd204_tx_lane_64b.sv - JESD204C 64b/66b TX lane: octet reorder, scrambler, CRC-12 sync header framing
module jesd204_tx_lane_64b (
    input  logic        clk,
    input  logic        resetn,
    input  logic        link_enable,
    input  logic        lemc_edge,
    input  logic [63:0] tx_data,
    output logic        tx_ready,
    input  logic        cfg_disable_scrambler,
    input  logic [1:0]  cfg_header_mode,
    input  logic [7:0]  cfg_mb_per_emb_m1,
    output logic [63:0] phy_data,
    output logic [1:0]  phy_header,
    output logic [1:0]  status_state,
    output logic        status_lemc_misalign
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t      state_q;
    logic [4:0]  blk_cnt_q;
    logic [7:0]  mb_cnt_q;
    logic        misalign_q;

    logic [63:0] r_d;
    logic [63:0] scr_data_d;
    logic [57:0] scr_q;
    logic [11:0] crc_acc_d;
    logic [11:0] crc_acc_q;
    logic [11:0] crc_prev_q;
    logic        s1_valid_q;
    logic [63:0] s1_data_q;
    logic [4:0]  s1_blk_q;
    logic [7:0]  s1_mb_q;
    logic [63:0] phy_data_q;
    logic [1:0]  phy_header_q;
    logic        hdr_bit;
    logic        emb_end;

    // h[121:64] holds the previous 58 scrambled bits, oldest at the top
    function automatic logic [63:0] scramble(input logic [57:0] st, input logic [63:0] r);
        logic [121:0] h;
        h = {st, 64'd0};
        for (int i = 63; i >= 0; i--) begin
            h[i] = r[i] ^ h[i + 39] ^ h[i + 58];
        end
        return h[63:0];
    endfunction

    function automatic logic [11:0] crc12(input logic [11:0] c_in, input logic [63:0] d);
        logic [11:0] c;
        c = c_in;
        for (int i = 63; i >= 0; i--) begin
            c = {c[10:0], 1'b0} ^ ((c[11] ^ d[i]) ? 12'h80F : 12'h000);
        end
        return c;
    endfunction

    function automatic logic sync_bit(input logic [4:0] blk, input logic [11:0] crc, input logic eoemb);
        logic b;
        case (blk)
            5'd0:  b = crc[11];
            5'd1:  b = crc[10];
            5'd2:  b = crc[9];
            5'd4:  b = crc[8];
            5'd5:  b = crc[7];
            5'd6:  b = crc[6];
            5'd8:  b = crc[5];
            5'd9:  b = crc[4];
            5'd10: b = crc[3];
            5'd12: b = crc[2];
            5'd13: b = crc[1];
            5'd14: b = crc[0];
            5'd3, 5'd7, 5'd11, 5'd15, 5'd19, 5'd31: b = 1'b1;
            5'd21: b = eoemb;
            default: b = 1'b0;
        endcase
        return b;
    endfunction

    assign emb_end      = (blk_cnt_q == 5'd31) && (mb_cnt_q == cfg_mb_per_emb_m1);
    assign tx_ready     = (state_q == ST_RUN);
    assign status_state = state_q;
    assign status_lemc_misalign = misalign_q;
    assign phy_data     = phy_data_q;
    assign phy_header   = phy_header_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            blk_cnt_q  <= 5'd0;
            mb_cnt_q   <= 8'd0;
            misalign_q <= 1'b0;
        end else begin
            if (!link_enable) begin
                state_q <= ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: state_q <= ST_WAIT;
                    ST_WAIT: if (lemc_edge) state_q <= ST_RUN;
                    ST_RUN:  state_q <= ST_RUN;
                    default: state_q <= ST_IDLE;
                endcase
            end

            if (state_q == ST_RUN) begin
                blk_cnt_q <= blk_cnt_q + 5'd1;
                if (blk_cnt_q == 5'd31) begin
                    mb_cnt_q <= (mb_cnt_q == cfg_mb_per_emb_m1) ? 8'd0 : mb_cnt_q + 8'd1;
                end
            end else begin
                blk_cnt_q <= 5'd0;
                mb_cnt_q  <= 8'd0;
            end

            // An edge off the boundary is only reported; the counters keep their phase
            if (state_q == ST_IDLE) begin
                misalign_q <= 1'b0;
            end else if (state_q == ST_RUN && lemc_edge && !emb_end) begin
                misalign_q <= 1'b1;
            end
        end
    end

    always_comb begin
        r_d = '0;
        if (state_q == ST_RUN) begin
            for (int i = 0; i < 8; i++) begin
                r_d[63 - 8*i -: 8] = tx_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        scr_data_d = cfg_disable_scrambler ? r_d : scramble(scr_q, r_d);
        crc_acc_d  = crc12((blk_cnt_q == 5'd0) ? 12'd0 : crc_acc_q, scr_data_d);
        hdr_bit    = sync_bit(s1_blk_q, (cfg_header_mode == 2'd0) ? crc_prev_q : 12'd0,
                              s1_mb_q == cfg_mb_per_emb_m1);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            scr_q        <= '0;
            crc_acc_q    <= '0;
            crc_prev_q   <= '0;
            s1_valid_q   <= 1'b0;
            s1_data_q    <= '0;
            s1_blk_q     <= '0;
            s1_mb_q      <= '0;
            phy_data_q   <= '0;
            phy_header_q <= 2'b01;
        end else begin
            // Bypass still shifts r in, so the state always tracks the last 58 line bits
            scr_q <= scr_data_d[57:0];
            if (state_q == ST_RUN) begin
                crc_acc_q <= crc_acc_d;
                if (blk_cnt_q == 5'd31) crc_prev_q <= crc_acc_d;
            end else begin
                crc_acc_q  <= '0;
                crc_prev_q <= '0;
            end

            s1_valid_q <= (state_q == ST_RUN);
            s1_data_q  <= scr_data_d;
            s1_blk_q   <= blk_cnt_q;
            s1_mb_q    <= mb_cnt_q;

            if (s1_valid_q) begin
                phy_data_q   <= s1_data_q;
                phy_header_q <= hdr_bit ? 2'b01 : 2'b10;
            end else begin
                phy_data_q   <= '0;
                phy_header_q <= 2'b01;
            end
        end
    end

endmodule

// File: tb/tb_jesd204_tx_lane_64b.sv
// tb/tb_jesd204_tx_lane_64b.sv - self-checking bench for jesd204_tx_lane_64b
module tb_jesd204_tx_lane_64b;

    logic        clk = 1'b0;
    logic        resetn;
    logic        link_enable;
    logic        lemc_edge;
    logic [63:0] tx_data;
    logic        tx_ready;
    logic        cfg_disable_scrambler;
    logic [1:0]  cfg_header_mode;
    logic [7:0]  cfg_mb_per_emb_m1;
    logic [63:0] phy_data;
    logic [1:0]  phy_header;
    logic [1:0]  status_state;
    logic        status_lemc_misalign;

    jesd204_tx_lane_64b dut (
        .clk                  (clk),
        .resetn               (resetn),
        .link_enable          (link_enable),
        .lemc_edge            (lemc_edge),
        .tx_data              (tx_data),
        .tx_ready             (tx_ready),
        .cfg_disable_scrambler(cfg_disable_scrambler),
        .cfg_header_mode      (cfg_header_mode),
        .cfg_mb_per_emb_m1    (cfg_mb_per_emb_m1),
        .phy_data             (phy_data),
        .phy_header           (phy_header),
        .status_state         (status_state),
        .status_lemc_misalign (status_lemc_misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [63:0] data;
        logic [1:0]  hdr;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    int          m_state;
    logic [4:0]  m_blk;
    logic [7:0]  m_mb;
    logic [57:0] m_scr;
    logic [11:0] m_acc;
    logic [11:0] m_prev;
    logic        m_mis;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (resetn) begin
            while (sb.size() > 0 && sb[0].due < cyc) begin
                mon_e = sb.pop_front();
                n_checks++;
                n_fail++;
                $display("FAIL sb_stale due=%0d now=%0d", mon_e.due, cyc);
            end
            if (sb.size() > 0 && sb[0].due == cyc) begin
                mon_e = sb.pop_front();
                n_checks++;
                if (phy_data !== mon_e.data || phy_header !== mon_e.hdr) begin
                    n_fail++;
                    $display("FAIL sb_phy cyc=%0d got data=%h hdr=%b expected data=%h hdr=%b",
                             cyc, phy_data, phy_header, mon_e.data, mon_e.hdr);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_state = 0; m_blk = 0; m_mb = 0; m_scr = 0;
        m_acc = 0; m_prev = 0; m_mis = 0;
        sb.delete();
    endtask

    // Bit-serial reference of one lane clock; pushes the output expected two cycles on
    task automatic tick();
        exp_t        e;
        logic [63:0] r;
        logic [63:0] s;
        logic [31:0] sw;
        logic [11:0] c;
        logic        ob;
        e.due = cyc + 2;
        r = (m_state == 2) ? {<<8{tx_data}} : 64'd0;
        if (m_state == 2 && m_blk == 5'd0) m_acc = 12'd0;
        for (int k = 63; k >= 0; k--) begin
            ob = cfg_disable_scrambler ? r[k] : (r[k] ^ m_scr[38] ^ m_scr[57]);
            m_scr = {m_scr[56:0], ob};
            s[k] = ob;
            m_acc = {m_acc[10:0], 1'b0} ^ ((m_acc[11] ^ ob) ? 12'h80F : 12'h000);
        end
        c  = (cfg_header_mode == 2'd0) ? m_prev : 12'd0;
        sw = 32'h8008_8888;
        for (int j = 0; j < 4; j++)
            for (int m = 0; m < 3; m++) sw[4*j + m] = c[11 - 3*j - m];
        sw[21] = (m_mb == cfg_mb_per_emb_m1);
        e.data = (m_state == 2) ? s : 64'd0;
        e.hdr  = (m_state == 2) ? (sw[m_blk] ? 2'b01 : 2'b10) : 2'b01;
        sb.push_back(e);

        if (m_state == 0) m_mis = 1'b0;
        else if (m_state == 2 && lemc_edge && !(m_blk == 5'd31 && m_mb == cfg_mb_per_emb_m1)) m_mis = 1'b1;
        if (m_state == 2) begin
            if (m_blk == 5'd31) begin
                m_prev = m_acc;
                m_mb = (m_mb == cfg_mb_per_emb_m1) ? 8'd0 : m_mb + 8'd1;
            end
            m_blk = m_blk + 5'd1;
        end else begin
            m_blk = 0; m_mb = 0;
        end
        if (!link_enable) m_state = 0;
        else if (m_state == 0) m_state = 1;
        else if (m_state == 1 && lemc_edge) begin
            m_state = 2; m_prev = 12'd0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic start_run();
        link_enable = 1'b1; lemc_edge = 1'b0;
        tick();
        lemc_edge = 1'b1;
        tick();
        lemc_edge = 1'b0;
    endtask

    task automatic go_idle();
        link_enable = 1'b0; lemc_edge = 1'b0; tx_data = '0;
        repeat (3) tick();
    endtask

    task automatic do_reset();
        resetn = 1'b0; link_enable = 1'b0; lemc_edge = 1'b0; tx_data = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; link_enable = 1'b0; lemc_edge = 1'b0; tx_data = '0;
        cfg_disable_scrambler = 1'b1; cfg_header_mode = 2'd0; cfg_mb_per_emb_m1 = 8'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks += 5;
        if (phy_data !== 64'd0) begin n_fail++; $display("FAIL reset_phy_data got=%h exp=0", phy_data); end
        if (phy_header !== 2'b01) begin n_fail++; $display("FAIL reset_phy_header got=%b exp=01", phy_header); end
        if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL reset_tx_ready got=%b exp=0", tx_ready); end
        if (status_state !== 2'd0) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", status_state); end
        if (status_lemc_misalign !== 1'b0) begin n_fail++; $display("FAIL reset_misalign got=%b exp=0", status_lemc_misalign); end
        resetn = 1'b1;
    endtask

    task automatic test_octet_order();
        start_run();
        n_checks++;
        if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL first_run_tx_ready got=%b exp=1", tx_ready); end
        tx_data = 64'h0706050403020100;
        tick();
        tx_data = '0;
        tick();
        n_checks++;
        if (phy_data !== 64'h0001020304050607) begin
            n_fail++; $display("FAIL octet_order got=%h exp=0001020304050607", phy_data);
        end
        go_idle();
    endtask

    task automatic test_sync_word();
        logic [31:0] got;
        start_run();
        tx_data = '0;
        repeat (2) tick();
        for (int i = 0; i < 32; i++) begin
            got[i] = (phy_header == 2'b01);
            tick();
        end
        n_checks++;
        if (got !== 32'h8028_8888) begin n_fail++; $display("FAIL sync_word_mb0 got=%h exp=80288888", got); end
        go_idle();
    endtask

    task automatic test_crc();
        logic [95:0] hb;
        logic [11:0] ref_crc;
        logic [11:0] got;
        ref_crc = 12'd0;
        for (int n = 0; n < 2048; n++) begin
            ref_crc = {ref_crc[10:0], 1'b0} ^ ((ref_crc[11] ^ (n == 0)) ? 12'h80F : 12'h000);
        end
        start_run();
        tx_data = 64'h80;
        tick();
        tx_data = '0;
        tick();
        for (int i = 0; i < 96; i++) begin
            hb[i] = (phy_header == 2'b01);
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 4; j++)
                for (int m = 0; m < 3; m++) got[11 - 3*j - m] = hb[32*k + 4*j + m];
            n_checks++;
            if (got !== ((k == 1) ? ref_crc : 12'd0)) begin
                n_fail++; $display("FAIL crc_mb%0d got=%h exp=%h", k, got, (k == 1) ? ref_crc : 12'd0);
            end
        end
        go_idle();
    endtask

    task automatic test_scrambler();
        do_reset();
        cfg_disable_scrambler = 1'b0; cfg_header_mode = 2'd0; cfg_mb_per_emb_m1 = 8'd0;
        start_run();
        tx_data = '0;
        repeat (4) tick();
        n_checks++;
        if (phy_data !== 64'd0) begin n_fail++; $display("FAIL scr_zero got=%h exp=0", phy_data); end
        tx_data = 64'h80;
        tick();
        tx_data = '0;
        tick();
        n_checks++;
        if (phy_data !== 64'h8000_0000_0100_0020) begin
            n_fail++; $display("FAIL scr_single_bit got=%h exp=8000000001000020", phy_data);
        end
        repeat (6) tick();
        go_idle();
    endtask

    task automatic test_emb();
        cfg_disable_scrambler = 1'b0; cfg_header_mode = 2'd2; cfg_mb_per_emb_m1 = 8'd3;
        start_run();
        repeat (2) begin tx_data = {$urandom, $urandom}; tick(); end
        for (int i = 0; i < 256; i++) begin
            if (i % 32 == 21) begin
                n_checks++;
                if (phy_header !== ((((i / 32) % 4) == 3) ? 2'b01 : 2'b10)) begin
                    n_fail++; $display("FAIL eoemb_mb%0d got=%b exp=%b", i / 32, phy_header,
                                       ((((i / 32) % 4) == 3) ? 2'b01 : 2'b10));
                end
            end
            tx_data = {$urandom, $urandom};
            tick();
        end
        for (int k = 0; k < 200 && !(m_blk == 5'd31 && m_mb == 8'd3); k++) tick();
        lemc_edge = 1'b1;
        tick();
        lemc_edge = 1'b0;
        n_checks++;
        if (status_lemc_misalign !== 1'b0) begin n_fail++; $display("FAIL lemc_aligned got=%b exp=0", status_lemc_misalign); end
        for (int k = 0; k < 200 && m_blk != 5'd10; k++) tick();
        lemc_edge = 1'b1;
        tick();
        lemc_edge = 1'b0;
        n_checks++;
        if (status_lemc_misalign !== 1'b1) begin n_fail++; $display("FAIL lemc_misalign got=%b exp=1", status_lemc_misalign); end
        repeat (40) begin tx_data = {$urandom, $urandom}; tick(); end
    endtask

    task automatic test_control();
        cfg_header_mode = 2'd0;
        for (int k = 0; k < 200 && m_blk != 5'd17; k++) begin tx_data = {$urandom, $urandom}; tick(); end
        link_enable = 1'b0;
        tx_data = {$urandom, $urandom};
        tick();
        n_checks += 2;
        if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL drop_tx_ready got=%b exp=0", tx_ready); end
        if (status_state !== 2'd0) begin n_fail++; $display("FAIL drop_state got=%0d exp=0", status_state); end
        repeat (2) tick();
        n_checks += 3;
        if (phy_data !== 64'd0) begin n_fail++; $display("FAIL drop_phy_data got=%h exp=0", phy_data); end
        if (phy_header !== 2'b01) begin n_fail++; $display("FAIL drop_phy_header got=%b exp=01", phy_header); end
        if (status_lemc_misalign !== 1'b0) begin n_fail++; $display("FAIL idle_misalign got=%b exp=0", status_lemc_misalign); end
        go_idle();
    endtask

    task automatic test_async_reset();
        cfg_disable_scrambler = 1'b0; cfg_header_mode = 2'd0; cfg_mb_per_emb_m1 = 8'd0;
        start_run();
        repeat (5) begin tx_data = {$urandom, $urandom}; tick(); end
        #2 resetn = 1'b0;
        model_reset();
        #1;
        n_checks += 4;
        if (phy_data !== 64'd0) begin n_fail++; $display("FAIL areset_phy_data got=%h exp=0", phy_data); end
        if (phy_header !== 2'b01) begin n_fail++; $display("FAIL areset_phy_header got=%b exp=01", phy_header); end
        if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL areset_tx_ready got=%b exp=0", tx_ready); end
        if (status_state !== 2'd0) begin n_fail++; $display("FAIL areset_state got=%0d exp=0", status_state); end
        link_enable = 1'b0;
        @(posedge clk);
        #1 resetn = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_drain();
        link_enable = 1'b0;
        repeat (4) tick();
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL sb_drain left=%0d exp=0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_octet_order();
        test_sync_word();
        test_crc();
        test_scrambler();
        test_emb();
        test_control();
        test_async_reset();
        test_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
